// File: rtl/div_job_feeder_if.sv
// Bundled stream, divider and result signals for div_job_feeder.
// slave = the feeder itself; master = the environment driving it.
interface div_job_feeder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_dividend;
  logic [DATA_W-1:0] in_divisor;

  logic              div_start;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic              div_idle;
  logic              div_finish;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_quotient;
  logic [DATA_W-1:0] res_remainder;
  logic              res_dbz;
  logic              res_timeout;

  logic              busy;

  modport master (
    output in_valid, in_dividend, in_divisor,
    output div_idle, div_finish, div_quotient, div_remainder,
    output res_ready,
    input  in_ready, div_start, div_dividend, div_divisor,
    input  res_valid, res_quotient, res_remainder, res_dbz, res_timeout, busy
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    input  div_idle, div_finish, div_quotient, div_remainder,
    input  res_ready,
    output in_ready, div_start, div_dividend, div_divisor,
    output res_valid, res_quotient, res_remainder, res_dbz, res_timeout, busy
  );
endinterface

// File: rtl/div_job_feeder.sv
// Queues dividend/divisor pairs, issues them one at a time to the divider and
// returns quotient/remainder with divide-by-zero and timeout flags.
module div_job_feeder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 127
) (
  input logic             i_clk,
  input logic             i_rst_n,
  div_job_feeder_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  logic [DATA_W-1:0] r_mem_dd [DEPTH];
  logic [DATA_W-1:0] r_mem_dv [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count, w_count_d;
  logic              r_full;
  state_e            r_state, w_state_d;
  logic [TmoW-1:0]   r_tmo_cnt;
  logic [DATA_W-1:0] r_op_dd, r_op_dv;
  logic [DATA_W-1:0] r_res_q, r_res_r;
  logic              r_res_dbz, r_res_tmo;
  logic              w_push, w_pop, w_load, w_capture, w_timeout;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = (r_state == StIssue);

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // FIFO storage, pointers, occupancy and registered full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_dd[i] <= '0;
        r_mem_dv[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_dd[r_wr_ptr] <= bus.in_dividend;
        r_mem_dv[r_wr_ptr] <= bus.in_divisor;
        r_wr_ptr           <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntW'(DEPTH));
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle: begin
        if ((r_count != '0) && bus.div_idle) begin
          w_state_d = StIssue;
          w_load    = 1'b1;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        // A finish on the last allowed cycle still counts as a finish.
        if (bus.div_finish) begin
          w_state_d = StHold;
          w_capture = 1'b1;
        end else if (r_tmo_cnt == TmoW'(TIMEOUT)) begin
          w_state_d = StHold;
          w_timeout = 1'b1;
        end
      end
      StHold: begin
        if (bus.res_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Operands are latched as ISSUE is entered so they are valid with div_start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_tmo_cnt <= '0;
      r_op_dd   <= '0;
      r_op_dv   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_tmo_cnt <= '0;
        r_op_dd   <= r_mem_dd[r_rd_ptr];
        r_op_dv   <= r_mem_dv[r_rd_ptr];
      end else if ((r_state == StIssue) || ((r_state == StWait) && (w_state_d == StWait))) begin
        r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_q   <= '0;
      r_res_r   <= '0;
      r_res_dbz <= 1'b0;
      r_res_tmo <= 1'b0;
    end else if (w_capture) begin
      r_res_tmo <= 1'b0;
      if (r_op_dv == '0) begin
        r_res_dbz <= 1'b1;
        r_res_q   <= '1;
        r_res_r   <= r_op_dd;
      end else begin
        r_res_dbz <= 1'b0;
        r_res_q   <= bus.div_quotient;
        r_res_r   <= bus.div_remainder;
      end
    end else if (w_timeout) begin
      r_res_tmo <= 1'b1;
      r_res_dbz <= (r_op_dv == '0);
      r_res_q   <= '0;
      r_res_r   <= '0;
    end
  end

  assign bus.in_ready      = ~r_full & i_rst_n;
  assign bus.div_start     = (r_state == StIssue);
  assign bus.div_dividend  = r_op_dd;
  assign bus.div_divisor   = r_op_dv;
  assign bus.res_valid     = (r_state == StHold);
  assign bus.res_quotient  = r_res_q;
  assign bus.res_remainder = r_res_r;
  assign bus.res_dbz       = r_res_dbz;
  assign bus.res_timeout   = r_res_tmo;
  assign bus.busy          = (r_state != StIdle) || (r_count != '0);
endmodule
